// File: rtl/pdp8_lpt.sv
// pdp8_lpt: LP08-style line-printer IOT device (code 66) with a character FIFO and strobe/ack printer handshake.
// Define LPT_IRQ_ENABLE_EN to add the interrupt-enable register (set by 6665) and drive io_interrupt.
module pdp8_lpt #(
    parameter logic [5:0]  DEV        = 6'o66,
    parameter logic [3:0]  EXEC_STATE = 4'd1,
    parameter int unsigned DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iot,
    input  logic [3:0]  state,
    input  logic [11:0] mb,
    input  logic [11:0] io_data_in,
    input  logic [5:0]  io_select,
    output logic        io_selected,
    output logic [11:0] io_data_out,
    output logic        io_data_avail,
    output logic        io_interrupt,
    output logic        io_skip,
    output logic [6:0]  lp_data,
    output logic        lp_strobe,
    input  logic        lp_ack,
    output logic        lp_overrun
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_RELEASE} lp_state_t;

    lp_state_t     lp_state, lp_state_nxt;
    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          ack_meta, ack_s;
    logic          exec, ready, ie_op;
    logic          push_req, push_ok, pop, ovr_set, ovr_clr;
    logic [6:0]    lp_data_nxt;
    logic          lp_strobe_nxt;
    logic          unused_bits;

    assign unused_bits   = ^{mb[11:3], io_data_in[11:7]};

    // Gating io_selected with reset forces every IOT-derived output low during reset.
    assign io_selected   = reset & iot & (io_select == DEV);
    assign exec          = io_selected & (state == EXEC_STATE);
    assign ready         = count < FULL_CNT;
    assign io_skip       = exec & mb[0] & ready & ~ie_op;
    assign push_req      = exec & mb[2] & ~ie_op;
    assign ovr_clr       = exec & mb[1];
    assign push_ok       = push_req & (ready | pop);
    assign ovr_set       = push_req & ~ready & ~pop;
    assign io_data_out   = '0;
    assign io_data_avail = 1'b0;

`ifdef LPT_IRQ_ENABLE_EN
    logic ie;

    assign ie_op        = exec & mb[0] & mb[2];
    assign io_interrupt = reset & ie & ready & ((count != '0) || (lp_state == ST_IDLE));

    always_ff @(posedge clk) begin
        if (!reset) begin
            ie <= 1'b0;
        end else if (ie_op) begin
            ie <= io_data_in[0];
        end
    end
`else
    assign ie_op        = 1'b0;
    assign io_interrupt = 1'b0;
`endif

    always_comb begin
        lp_state_nxt  = lp_state;
        lp_data_nxt   = lp_data;
        lp_strobe_nxt = lp_strobe;
        pop           = 1'b0;
        case (lp_state)
            ST_IDLE: begin
                if ((count != '0) && !ack_s) begin
                    lp_data_nxt   = mem[rd_ptr];
                    lp_strobe_nxt = 1'b1;
                    lp_state_nxt  = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (ack_s) begin
                    pop           = 1'b1;
                    lp_strobe_nxt = 1'b0;
                    lp_state_nxt  = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    lp_state_nxt = ST_IDLE;
                end
            end
            default: lp_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lp_state   <= ST_IDLE;
            lp_data    <= '0;
            lp_strobe  <= 1'b0;
            ack_meta   <= 1'b0;
            ack_s      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            lp_overrun <= 1'b0;
        end else begin
            lp_state  <= lp_state_nxt;
            lp_data   <= lp_data_nxt;
            lp_strobe <= lp_strobe_nxt;
            ack_meta  <= lp_ack;
            ack_s     <= ack_meta;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push_ok) begin
                count <= count - (AW+1)'(1);
            end
            if (ovr_set) begin
                lp_overrun <= 1'b1;
            end else if (ovr_clr) begin
                lp_overrun <= 1'b0;
            end
        end
    end

    // The head is already copied into lp_data, so a full-FIFO push may reuse the slot being popped.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= io_data_in[6:0];
        end
    end

endmodule

// File: tb/tb_pdp8_lpt.sv
// Scoreboard bench for pdp8_lpt: expected printed characters are queued at push time, a monitor checks each strobe.
module tb_pdp8_lpt;
    localparam int         DEPTH = 4;
    localparam logic [3:0] EXEC  = 4'd1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        iot = 1'b0;
    logic [3:0]  state = 4'd0;
    logic [11:0] mb = '0;
    logic [11:0] io_data_in = '0;
    logic [5:0]  io_select = '0;
    logic        io_selected, io_data_avail, io_interrupt, io_skip;
    logic [11:0] io_data_out;
    logic [6:0]  lp_data;
    logic        lp_strobe, lp_overrun;
    logic        lp_ack;
    logic        man_ack = 1'b0;
    logic        auto_ack = 1'b0;
    logic        prn_ack;

    int          tests = 0;
    int          fails = 0;
    logic [6:0]  sb [$];
    int          mcnt = 0;
    logic        movr = 1'b0;

    logic        mon_prev = 1'b0;
    logic [6:0]  mon_held = '0;
    logic        mon_unstable = 1'b0;
    logic [6:0]  mon_exp;
    int          prn_dly = 0;

    assign lp_ack = auto_ack ? prn_ack : man_ack;

    pdp8_lpt #(.DEV(6'o66), .EXEC_STATE(4'd1), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .iot(iot), .state(state), .mb(mb),
        .io_data_in(io_data_in), .io_select(io_select), .io_selected(io_selected),
        .io_data_out(io_data_out), .io_data_avail(io_data_avail), .io_interrupt(io_interrupt),
        .io_skip(io_skip), .lp_data(lp_data), .lp_strobe(lp_strobe), .lp_ack(lp_ack),
        .lp_overrun(lp_overrun)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0o required %0o", name, act, exp);
        end
    endtask

    task automatic do_iot(input logic [5:0] sel, input logic [11:0] op, input logic [11:0] ac,
                          output logic skip, output logic sel_o);
        @(negedge clk);
        iot = 1'b1; io_select = sel; mb = op; io_data_in = ac; state = EXEC;
        #1;
        skip  = io_skip;
        sel_o = io_selected;
        @(posedge clk);
        #1;
        iot = 1'b0; state = 4'd0; mb = '0;
    endtask

    // Reference: FIFO occupancy only grows while the printer withholds ack.
    task automatic mpush(input logic [11:0] op, input logic [11:0] ac, output logic skip);
        logic so;
        logic dropped;
        logic [6:0] ch;
        ch = ac[6:0];
        dropped = (mcnt >= DEPTH);
        if (!dropped) begin
            sb.push_back(ch);
            mcnt++;
        end
        if (dropped) movr = 1'b1;
        else if (op[1]) movr = 1'b0;
        do_iot(op[8:3], op, ac, skip, so);
    endtask

    task automatic wait_strobe(input logic lvl, input string name);
        int n;
        n = 0;
        while (lp_strobe !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, lp_strobe, lvl);
    endtask

    task automatic drain();
        int n;
        n = 0;
        auto_ack = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!(sb.size() == 0 && !lp_strobe && !lp_ack) && n < 3000);
        check("drain_done", n < 3000, 1'b1);
        repeat (4) @(negedge clk);
        man_ack  = 1'b0;
        auto_ack = 1'b0;
        mcnt     = 0;
    endtask

    // Printer model: answers strobe edges after a random delay.
    initial begin
        prn_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_ack) begin
                if (lp_strobe != prn_ack) begin
                    if (prn_dly == 0) begin
                        prn_ack = lp_strobe;
                        prn_dly = $urandom_range(0, 3);
                    end else begin
                        prn_dly--;
                    end
                end
            end else begin
                prn_ack = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (lp_strobe && !mon_prev) begin
                mon_held     = lp_data;
                mon_unstable = 1'b0;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_strobe: got data %0o, required no strobe", lp_data);
                end else begin
                    mon_exp = sb.pop_front();
                    check("lp_data", mon_held, mon_exp);
                end
            end else if (lp_strobe && lp_data !== mon_held) begin
                mon_unstable = 1'b1;
            end
            if (!lp_strobe && mon_prev) check("data_stable", mon_unstable, 1'b0);
            mon_prev = lp_strobe;
        end
    end

    initial begin
        logic s, so;
        logic [6:0] c4;
        logic [11:0] op, ac;
        int n, r;

        repeat (2) @(negedge clk);
        iot = 1'b1; io_select = 6'o66; mb = 12'o6661; state = EXEC;
        #1;
        check("sel_in_reset", io_selected, 1'b0);
        check("skip_in_reset", io_skip, 1'b0);
        @(posedge clk);
        #1;
        iot = 1'b0; state = 4'd0; mb = '0;
        check("rst_strobe", lp_strobe, 1'b0);
        check("rst_data", lp_data, 12'o0);
        check("rst_ovr", lp_overrun, 1'b0);
        check("data_out", io_data_out, 12'o0);
        check("data_avail", io_data_avail, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        do_iot(6'o66, 12'o6661, 12'o0, s, so);
        check("t1_skip", s, 1'b1);
        check("t1_sel", so, 1'b1);
        do_iot(6'o03, 12'o6661, 12'o0, s, so);
        check("t1_other_skip", s, 1'b0);
        check("t1_other_sel", so, 1'b0);

        mpush(12'o6664, 12'o0301, s);
        drain();
        do_iot(6'o66, 12'o6661, 12'o0, s, so);
        check("t2_empty_skip", s, 1'b1);

        for (int i = 0; i < 5; i++) begin
            do_iot(6'o66, 12'o6661, 12'o0, s, so);
            check("t3_skip", s, mcnt < DEPTH);
            mpush(12'o6664, 12'o0011 + 12'(i), s);
        end
        check("t3_ovr_set", lp_overrun, 1'b1);
        do_iot(6'o66, 12'o6662, 12'o0, s, so);
        movr = 1'b0;
        check("t3_ovr_clr", lp_overrun, 1'b0);
        drain();

        for (int i = 0; i < 4; i++) mpush(12'o6664, 12'o0140 + 12'(i), s);
        wait_strobe(1'b1, "t4_strobe");
        do_iot(6'o66, 12'o6661, 12'o0, s, so);
        check("t4_full_skip", s, 1'b0);
        @(negedge clk);
        man_ack = 1'b1;
        @(posedge clk);
        @(posedge clk);
        c4 = 7'o155;
        sb.push_back(c4);
        do_iot(6'o66, 12'o6664, {5'b0, c4}, s, so);
        check("t4_no_ovr", lp_overrun, 1'b0);
        do_iot(6'o66, 12'o6661, 12'o0, s, so);
        check("t4_still_full", s, 1'b0);
        drain();

        mpush(12'o6664, 12'o0052, s);
        mpush(12'o6664, 12'o0053, s);
        wait_strobe(1'b1, "t5_strobe");
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        check("t5_strobe_pre", lp_strobe, 1'b1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        mcnt = 0;
        movr = 1'b0;
        check("t5_rst_strobe", lp_strobe, 1'b0);
        reset = 1'b1;
        do_iot(6'o66, 12'o6661, 12'o0, s, so);
        check("t5_empty_skip", s, 1'b1);
        mpush(12'o6664, 12'o0077, s);
        repeat (6) @(negedge clk);
        check("t5_hold_off", lp_strobe, 1'b0);
        man_ack = 1'b0;
        wait_strobe(1'b1, "t5_strobe_after");
        drain();

`ifdef LPT_IRQ_ENABLE_EN
        check("irq_off", io_interrupt, 1'b0);
        do_iot(6'o66, 12'o6665, 12'o0001, s, so);
        check("irq_en_noskip", s, 1'b0);
        check("irq_on", io_interrupt, 1'b1);
        for (int i = 0; i < 4; i++) mpush(12'o6664, 12'o0020 + 12'(i), s);
        check("irq_full", io_interrupt, 1'b0);
        do_iot(6'o66, 12'o6665, 12'o0000, s, so);
        check("irq_dis", io_interrupt, 1'b0);
        check("irq_no_ovr", lp_overrun, movr);
        drain();
`else
        check("irq_tied", io_interrupt, 1'b0);
        mpush(12'o6665, 12'o0123, s);
        check("op6665_skip", s, 1'b1);
        drain();
`endif

        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                do_iot(6'o66, 12'o6661, 12'o0, s, so);
                check("rnd_skip", s, mcnt < DEPTH);
                r = $urandom_range(0, 3);
                if (r == 0) begin
                    do_iot(6'o66, 12'o6662, 12'o0, s, so);
                    movr = 1'b0;
                end
                op = ($urandom_range(0, 1) == 1) ? 12'o6666 : 12'o6664;
                ac = 12'($urandom);
                mpush(op, ac, s);
            end
            check("rnd_ovr", lp_overrun, movr);
            drain();
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
